instr_feeder: RTL

//  Instruction source for the 4-bit multi-cycle datapath: holds a small program memory plus a program counter.

---
 rtl/instr_feeder_if.sv | 31 +++
 rtl/instr_feeder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/instr_feeder_if.sv
// Host/datapath-facing bus of the instruction feeder.
// master: the host/loader side that drives control and program words.
// slave:  the feeder itself.
interface instr_feeder_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AW    = 3
);
  logic             load_en;
  logic [AW-1:0]    load_addr;
  logic [WIDTH-1:0] load_data;
  logic [AW-1:0]    last_addr;
  logic             start;
  logic             halt_req;
  logic [WIDTH-1:0] next;
  logic [AW-1:0]    pc;
  logic [1:0]       phase;
  logic             running;
  logic             done;
  logic             load_err;
  logic [7:0]       retired;

  modport master (
    output load_en, load_addr, load_data, last_addr, start, halt_req,
    input  next, pc, phase, running, done, load_err, retired
  );

  modport slave (
    input  load_en, load_addr, load_data, last_addr, start, halt_req,
    output next, pc, phase, running, done, load_err, retired
  );
endinterface

// File: rtl/instr_feeder.sv
// instr_feeder: program memory + program counter feeding a 4-cycle
// IF/ID/EX/WB consumer. Each instruction is held on `next` for one full
// window; `phase` tracks the consumer's step inside that window.
// Optional feature macro: LOOP_EN -- when defined, reaching the last
// instruction wraps back to address 0 instead of finishing; only a halt
// request ends the run.
module instr_feeder #(
  parameter int unsigned      WIDTH     = 4,
  parameter int unsigned      DEPTH     = 8,
  parameter int unsigned      AW        = 3,
  parameter logic [WIDTH-1:0] IDLE_INSN = '0
) (
  input  logic           clk,
  input  logic           rst,
  instr_feeder_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] next_q;
  logic [AW-1:0]    pc_q;
  logic [AW-1:0]    end_addr;
  logic [1:0]       phase_q;
  logic             done_q;
  logic             load_err_q;
  logic             halt_seen;
  logic [7:0]       retired_q;

  logic             wr_ok;
  logic             start_go;
  logic [WIDTH-1:0] first_insn;
  logic [AW-1:0]    pc_inc;
  logic             window_end;
  logic             halt_now;
  logic             at_end;

  // Decode of the per-cycle decisions shared by memory and control.
  always_comb begin
    wr_ok      = bus.load_en && (state == ST_IDLE) && !rst;
    start_go   = (state == ST_IDLE) && bus.start;
    // A word written to address 0 in the start cycle is not in memory yet,
    // so it is forwarded straight to `next`.
    first_insn = (wr_ok && (bus.load_addr == '0)) ? bus.load_data : mem[0];
    pc_inc     = pc_q + 1'b1;
    window_end = (state == ST_RUN) && (phase_q == 2'd3);
    halt_now   = halt_seen || bus.halt_req;
    at_end     = (pc_q == end_addr);
  end

  // Program memory: written only while idle, never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[bus.load_addr] <= bus.load_data;
  end

  // Sequencer: state, program counter, phase, and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      next_q     <= IDLE_INSN;
      pc_q       <= '0;
      end_addr   <= '0;
      phase_q    <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      halt_seen  <= 1'b0;
      retired_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      load_err_q <= (state == ST_RUN) && bus.load_en;

      case (state)
        ST_IDLE: begin
          if (start_go) begin
            state     <= ST_RUN;
            next_q    <= first_insn;
            pc_q      <= '0;
            phase_q   <= '0;
            retired_q <= '0;
            end_addr  <= bus.last_addr;
            halt_seen <= 1'b0;
          end
        end

        ST_RUN: begin
          if (!window_end) begin
            phase_q   <= phase_q + 2'd1;
            halt_seen <= halt_now;
          end else begin
            if (retired_q != 8'hFF)
              retired_q <= retired_q + 8'd1;
            phase_q   <= '0;
            halt_seen <= 1'b0;
            if (halt_now) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
              next_q <= IDLE_INSN;
            end else if (at_end) begin
`ifdef LOOP_EN
              pc_q   <= '0;
              next_q <= mem[0];
`else
              state  <= ST_IDLE;
              done_q <= 1'b1;
              next_q <= IDLE_INSN;
`endif
            end else begin
              pc_q   <= pc_inc;
              next_q <= mem[pc_inc];
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.next     = next_q;
  assign bus.pc       = pc_q;
  assign bus.phase    = phase_q;
  assign bus.running  = (state == ST_RUN);
  assign bus.done     = done_q;
  assign bus.load_err = load_err_q;
  assign bus.retired  = retired_q;

  // Structural invariants of the sequencer.
  a_idle_phase : assert property (@(posedge clk) disable iff (rst)
    (state == ST_IDLE) |-> (phase_q == 2'd0));
  a_done_idle  : assert property (@(posedge clk) disable iff (rst)
    done_q |-> (state == ST_IDLE));
  a_next_hold  : assert property (@(posedge clk) disable iff (rst)
    ((state == ST_RUN) && (phase_q != 2'd3)) |=> $stable(next_q));

endmodule
